pc_seq_unit: RTL and testbench

PC_SEQ_UNIT -- requirements
Module: pc_seq_unit

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_redir_sel.sv | 25 ++
 rtl/pc_seq_unit.sv | 135 +++++++++++++
 tb/tb_pc_seq_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared FSM encoding and default vector addresses for the fetch PC sequencer.
package pc_pkg;

    typedef enum logic [2:0] {
        RST_VEC  = 3'd0,
        RST_LOAD = 3'd1,
        RUN      = 3'd2,
        INT_VEC  = 3'd3,
        INT_LOAD = 3'd4
    } pc_state_e;

    localparam int DEF_RESET_VEC_ADDR = 0;
    localparam int DEF_INT_VEC_ADDR   = 1;

endpackage

// File: rtl/pc_redir_sel.sv
// Priority select across redirect channels: channel 0 (oldest stage) wins.
// Purely combinational; reports whether any channel is valid plus the winning target.
module pc_redir_sel #(
    parameter int ADDR_W    = 8,
    parameter int NUM_REDIR = 4
) (
    input  logic [NUM_REDIR-1:0]        redir_valid_i,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_target_i,
    output logic                        any_vld_o,
    output logic [ADDR_W-1:0]           target_o
);

    always_comb begin
        any_vld_o = 1'b0;
        target_o  = '0;
        // Walk from the youngest channel down so the lowest index overwrites last.
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid_i[i]) begin
                any_vld_o = 1'b1;
                target_o  = redir_target_i[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch PC sequencer: reset-vector boot, prioritised redirects, stall, optional interrupt entry.
// Interrupt support is compiled in only when PC_SEQ_INT_EN is defined.
module pc_seq_unit
    import pc_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int NUM_REDIR      = 4,
    parameter int RESET_VEC_ADDR = DEF_RESET_VEC_ADDR,
    parameter int INT_VEC_ADDR   = DEF_INT_VEC_ADDR
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic [NUM_REDIR-1:0]        redir_valid,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_target,
    input  logic [ADDR_W-1:0]           vec_data,
    input  logic                        irq,
    output logic [ADDR_W-1:0]           pc,
    output logic                        pc_valid,
    output logic                        vec_fetch,
    output logic [ADDR_W-1:0]           vec_addr,
    output logic                        irq_ack,
    output logic [ADDR_W-1:0]           int_ret_pc
);

    pc_state_e         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              redir_any;
    logic [ADDR_W-1:0] redir_tgt;

    pc_redir_sel #(
        .ADDR_W    (ADDR_W),
        .NUM_REDIR (NUM_REDIR)
    ) u_redir_sel (
        .redir_valid_i  (redir_valid),
        .redir_target_i (redir_target),
        .any_vld_o      (redir_any),
        .target_o       (redir_tgt)
    );

`ifdef PC_SEQ_INT_EN
    logic [ADDR_W-1:0] int_ret_q;
    logic              irq_ack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_VEC;
            pc_q      <= '0;
            int_ret_q <= '0;
            irq_ack_q <= 1'b0;
        end else begin
            irq_ack_q <= 1'b0;
            case (state_q)
                RST_VEC:  state_q <= RST_LOAD;
                RST_LOAD: begin
                    pc_q    <= vec_data;
                    state_q <= RUN;
                end
                RUN: begin
                    if (redir_any) begin
                        pc_q <= redir_tgt;
                    end else if (!stall) begin
                        if (irq) begin
                            int_ret_q <= pc_q;
                            irq_ack_q <= 1'b1;
                            state_q   <= INT_VEC;
                        end else begin
                            pc_q <= pc_q + 1'b1;
                        end
                    end
                end
                INT_VEC: begin
                    // A late branch from an older instruction replaces the return point.
                    if (redir_any) int_ret_q <= redir_tgt;
                    state_q <= INT_LOAD;
                end
                INT_LOAD: begin
                    if (redir_any) int_ret_q <= redir_tgt;
                    pc_q    <= vec_data;
                    state_q <= RUN;
                end
                default: state_q <= RST_VEC;
            endcase
        end
    end

    assign irq_ack    = irq_ack_q;
    assign int_ret_pc = int_ret_q;
`else
    logic unused_irq;
    assign unused_irq = irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_VEC;
            pc_q    <= '0;
        end else begin
            case (state_q)
                RST_VEC:  state_q <= RST_LOAD;
                RST_LOAD: begin
                    pc_q    <= vec_data;
                    state_q <= RUN;
                end
                RUN: begin
                    if (redir_any) begin
                        pc_q <= redir_tgt;
                    end else if (!stall) begin
                        pc_q <= pc_q + 1'b1;
                    end
                end
                default: state_q <= RST_VEC;
            endcase
        end
    end

    assign irq_ack    = 1'b0;
    assign int_ret_pc = '0;
`endif

    always_comb begin
        vec_fetch = 1'b0;
        vec_addr  = '0;
        if (state_q == RST_VEC) begin
            vec_fetch = 1'b1;
            vec_addr  = ADDR_W'(RESET_VEC_ADDR);
        end else if (state_q == INT_VEC) begin
            vec_fetch = 1'b1;
            vec_addr  = ADDR_W'(INT_VEC_ADDR);
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == RUN);

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit; interrupt scenarios run when PC_SEQ_INT_EN is defined.
module tb_pc_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [3:0]  redir_valid;
    logic [31:0] redir_target;
    logic [7:0]  vec_data;
    logic        irq;
    logic [7:0]  pc;
    logic        pc_valid;
    logic        vec_fetch;
    logic [7:0]  vec_addr;
    logic        irq_ack;
    logic [7:0]  int_ret_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_seq_unit #(
        .ADDR_W         (8),
        .NUM_REDIR      (4),
        .RESET_VEC_ADDR (0),
        .INT_VEC_ADDR   (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .vec_data     (vec_data),
        .irq          (irq),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .vec_fetch    (vec_fetch),
        .vec_addr     (vec_addr),
        .irq_ack      (irq_ack),
        .int_ret_pc   (int_ret_pc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_pc;
        rst          = 1'b1;
        stall        = 1'b0;
        redir_valid  = 4'b0000;
        redir_target = 32'h0;
        vec_data     = 8'h40;
        irq          = 1'b0;

        step();
        step();
        check("rst_pc", pc, 8'h00);
        check("rst_pc_valid", pc_valid, 1'b0);
        check("rst_irq_ack", irq_ack, 1'b0);
        check("rst_int_ret", int_ret_pc, 8'h00);

        // First cycle after release: reset vector fetch.
        rst = 1'b0;
        check("boot_vec_fetch", vec_fetch, 1'b1);
        check("boot_vec_addr", vec_addr, 8'h00);
        check("boot_pc_valid0", pc_valid, 1'b0);
        step();
        check("load_vec_fetch", vec_fetch, 1'b0);
        check("load_vec_addr", vec_addr, 8'h00);
        check("load_pc_valid", pc_valid, 1'b0);
        // Redirect while booting must be ignored.
        redir_valid  = 4'b0001;
        redir_target = 32'h0000_0077;
        step();
        redir_valid = 4'b0000;
        check("boot_pc", pc, 8'h40);
        check("boot_pc_valid", pc_valid, 1'b1);
        step();
        check("run_pc41", pc, 8'h41);
        step();
        check("run_pc42", pc, 8'h42);

        // Priority: ch1 beats ch2, stall does not block redirect.
        stall        = 1'b1;
        redir_valid  = 4'b0110;
        redir_target = 32'h0020_1000;
        step();
        check("prio_pc", pc, 8'h10);
        redir_valid = 4'b0000;
        step();
        check("stall_hold", pc, 8'h10);

        // All channels valid: ch0 wins.
        redir_valid  = 4'b1111;
        redir_target = 32'hAABB_CC35;
        step();
        check("prio_ch0", pc, 8'h35);

        // Wrap from all-ones.
        redir_valid  = 4'b1000;
        redir_target = 32'hFF00_0000;
        step();
        check("wrap_pre", pc, 8'hFF);
        redir_valid = 4'b0000;
        stall       = 1'b0;
        step();
        check("wrap_pc", pc, 8'h00);

`ifdef PC_SEQ_INT_EN
        // Return to pc 0x35, then take an interrupt.
        redir_valid  = 4'b0001;
        redir_target = 32'h0000_0035;
        step();
        redir_valid = 4'b0000;
        check("int_pre_pc", pc, 8'h35);
        // irq blocked while stalled.
        irq   = 1'b1;
        stall = 1'b1;
        step();
        check("int_block_stall", irq_ack, 1'b0);
        check("int_block_pc_valid", pc_valid, 1'b1);
        stall    = 1'b0;
        vec_data = 8'h80;
        step();
        irq = 1'b0;
        check("int_ack", irq_ack, 1'b1);
        check("int_ret", int_ret_pc, 8'h35);
        check("int_vec_fetch", vec_fetch, 1'b1);
        check("int_vec_addr", vec_addr, 8'h01);
        check("int_pc_valid", pc_valid, 1'b0);
        step();
        check("int_ack_clear", irq_ack, 1'b0);
        check("int_load_vec_fetch", vec_fetch, 1'b0);
        step();
        check("int_pc", pc, 8'h80);
        check("int_run_valid", pc_valid, 1'b1);

        // Late ch0 redirect during INT_VEC replaces the return PC.
        irq = 1'b1;
        step();
        irq = 1'b0;
        check("int2_ret", int_ret_pc, 8'h80);
        redir_valid  = 4'b0011;
        redir_target = 32'h0000_6650;
        step();
        redir_valid = 4'b0000;
        check("int2_ret_redir", int_ret_pc, 8'h50);

        // Reset while in INT_LOAD.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("int_rst_ret", int_ret_pc, 8'h00);
        check("int_rst_pc", pc, 8'h00);
        check("int_rst_vec_fetch", vec_fetch, 1'b1);
        check("int_rst_vec_addr", vec_addr, 8'h00);
        check("int_rst_pc_valid", pc_valid, 1'b0);
`else
        // irq must be ignored entirely in this build.
        irq    = 1'b1;
        exp_pc = 8'h00;
        for (int i = 0; i < 20; i++) begin
            step();
            exp_pc = exp_pc + 8'h01;
            check("noint_ack", irq_ack, 1'b0);
            check("noint_pc", pc, exp_pc);
        end
        check("noint_ret", int_ret_pc, 8'h00);
        check("noint_vec_fetch", vec_fetch, 1'b0);
        irq = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
